// File: rtl/alu_pipe_if.sv
// Handshake bundle between operand fetch, the ALU pipe and writeback.
//   in_valid/in_ready   : operation request handshake (operand1, operand2, opcode)
//   out_valid/out_ready : result handshake (result, illegal)
// master: upstream/downstream side driving requests and consuming results.
// slave : the ALU pipe.
interface alu_pipe_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] operand1;
    logic [WIDTH-1:0] operand2;
    logic [3:0]       opcode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   result;
    logic             illegal;

    modport master (
        output in_valid, operand1, operand2, opcode, out_ready,
        input  in_ready, out_valid, result, illegal
    );

    modport slave (
        input  in_valid, operand1, operand2, opcode, out_ready,
        output in_ready, out_valid, result, illegal
    );
endinterface

// File: rtl/alu_pipe.sv
// Handshaked ALU with a registered output and an iterative shift-add multiplier.
// Ports:
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : alu_pipe_if slave (request in, result out)
// Single-cycle ops load the output register on the accepting edge. MUL walks one
// multiplier bit per cycle and loads the output WIDTH edges after acceptance.
module alu_pipe #(
    parameter int unsigned WIDTH  = 32,
    parameter bit          MUL_EN = 1'b1
) (
    input  logic       clock,
    input  logic       reset_n,
    alu_pipe_if.slave  bus
);
    localparam int unsigned CW = $clog2(WIDTH);

    localparam logic [3:0] OpAdd  = 4'b0001;
    localparam logic [3:0] OpSub  = 4'b0010;
    localparam logic [3:0] OpAnd  = 4'b0011;
    localparam logic [3:0] OpOr   = 4'b0100;
    localparam logic [3:0] OpXor  = 4'b0101;
    localparam logic [3:0] OpSll  = 4'b0110;
    localparam logic [3:0] OpSrl  = 4'b0111;
    localparam logic [3:0] OpSra  = 4'b1000;
    localparam logic [3:0] OpSlt  = 4'b1001;
    localparam logic [3:0] OpSltu = 4'b1010;
    localparam logic [3:0] OpMul  = 4'b1011;

    typedef enum logic [0:0] {StIdle, StMul} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH:0]   result_q, result_d;
    logic             illegal_q, illegal_d;

    logic             accept;
    logic             is_mul;
    logic             out_blocked;
    logic             complete;
    logic             big_shift;
    logic [CW-1:0]    shamt;
    logic [WIDTH-1:0] sra_val;
    logic [WIDTH:0]   alu_res;
    logic             alu_ill;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH-1:0] hi_step;
    logic [WIDTH-1:0] lo_step;

    assign bus.in_ready  = (state_q == StIdle) && (!out_valid_q || bus.out_ready);
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.illegal   = illegal_q;

    assign accept      = bus.in_valid && bus.in_ready;
    assign is_mul      = MUL_EN && (bus.opcode == OpMul);
    assign out_blocked = out_valid_q && !bus.out_ready;

    // Shift amounts of WIDTH or more saturate; below that the low CW bits suffice.
    assign big_shift = {1'b0, bus.operand2} >= (WIDTH+1)'(WIDTH);
    assign shamt     = bus.operand2[CW-1:0];
    assign sra_val   = $signed(bus.operand1) >>> shamt;

    always_comb begin
        alu_res = '0;
        alu_ill = 1'b0;
        case (bus.opcode)
            OpAdd:  alu_res = {1'b0, bus.operand1} + {1'b0, bus.operand2};
            OpSub:  alu_res = {1'b0, bus.operand1} - {1'b0, bus.operand2};
            OpAnd:  alu_res = {1'b0, bus.operand1 & bus.operand2};
            OpOr:   alu_res = {1'b0, bus.operand1 | bus.operand2};
            OpXor:  alu_res = {1'b0, bus.operand1 ^ bus.operand2};
            OpSll:  alu_res = big_shift ? '0 : {1'b0, bus.operand1 << shamt};
            OpSrl:  alu_res = big_shift ? '0 : {1'b0, bus.operand1 >> shamt};
            OpSra:  alu_res = big_shift ? {1'b0, {WIDTH{bus.operand1[WIDTH-1]}}}
                                        : {1'b0, sra_val};
            OpSlt:  alu_res = {{WIDTH{1'b0}}, $signed(bus.operand1) < $signed(bus.operand2)};
            OpSltu: alu_res = {{WIDTH{1'b0}}, bus.operand1 < bus.operand2};
            default: alu_ill = 1'b1;
        endcase
    end

    // One shift-add step: {hi,lo} holds the partial product with the unused
    // multiplier bits in the low end of lo.
    assign add_sum = {1'b0, hi_q} + {1'b0, (lo_q[0] ? mcand_q : {WIDTH{1'b0}})};
    assign hi_step = add_sum[WIDTH:1];
    assign lo_step = {add_sum[0], lo_q[WIDTH-1:1]};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mcand_d   = mcand_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        result_d  = result_q;
        illegal_d = illegal_q;
        complete  = 1'b0;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    if (is_mul) begin
                        state_d = StMul;
                        cnt_d   = '0;
                        mcand_d = bus.operand1;
                        hi_d    = '0;
                        lo_d    = bus.operand2;
                    end else begin
                        complete  = 1'b1;
                        result_d  = alu_res;
                        illegal_d = alu_ill;
                    end
                end
            end
            StMul: begin
                // Stall with counter and partial product intact until the output frees.
                if (!out_blocked) begin
                    hi_d  = hi_step;
                    lo_d  = lo_step;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_d   = StIdle;
                        complete  = 1'b1;
                        result_d  = {|hi_step, lo_step};
                        illegal_d = 1'b0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (complete) begin
            out_valid_d = 1'b1;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            mcand_q     <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mcand_q     <= mcand_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            illegal_q   <= illegal_d;
        end
    end
endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe at WIDTH=32, MUL_EN=1.
module tb_alu_pipe;
    logic clock;
    logic reset_n;
    int   n_checks;
    int   n_fail;

    alu_pipe_if #(.WIDTH(32)) bus ();

    alu_pipe #(.WIDTH(32), .MUL_EN(1'b1)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drive one op at a falling edge, accept on the next rising edge, return 1 after it.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        bus.opcode   = op;
        bus.operand1 = a;
        bus.operand2 = b;
        bus.in_valid = 1'b1;
        @(posedge clock);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.result !== 33'd0 || bus.illegal !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got v=%b r=%h i=%b required v=0 r=0 i=0",
                     bus.out_valid, bus.result, bus.illegal);
        end
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b required 1", bus.in_ready);
        end
    endtask

    task automatic test_add();
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL add_pre_valid: got %b required 0", bus.out_valid);
        end
        issue(4'b0001, 32'd50, 32'd10);
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.result !== 33'd60 || bus.illegal !== 1'b0) begin
            n_fail++;
            $display("FAIL add_50_10: got v=%b r=%h i=%b required v=1 r=3c i=0",
                     bus.out_valid, bus.result, bus.illegal);
        end
        issue(4'b0001, 32'hFFFF_FFFF, 32'd1);
        n_checks++;
        if (bus.result !== 33'h1_0000_0000) begin
            n_fail++;
            $display("FAIL add_carry: got %h required 100000000", bus.result);
        end
    endtask

    task automatic test_sub_cmp();
        issue(4'b0010, 32'd10, 32'd50);
        n_checks++;
        if (bus.result !== 33'h1_FFFF_FFD8) begin
            n_fail++;
            $display("FAIL sub_borrow: got %h required 1ffffffd8", bus.result);
        end
        issue(4'b1001, 32'hFFFF_FFFB, 32'd3);
        n_checks++;
        if (bus.result !== 33'd1) begin
            n_fail++;
            $display("FAIL slt_signed: got %h required 1", bus.result);
        end
        issue(4'b1010, 32'hFFFF_FFFB, 32'd3);
        n_checks++;
        if (bus.result !== 33'd0) begin
            n_fail++;
            $display("FAIL sltu_unsigned: got %h required 0", bus.result);
        end
    endtask

    task automatic test_logic_shift();
        issue(4'b1000, 32'h8000_0000, 32'd4);
        n_checks++;
        if (bus.result !== 33'h0_F800_0000) begin
            n_fail++;
            $display("FAIL sra_4: got %h required 0f8000000", bus.result);
        end
        issue(4'b0110, 32'd1, 32'd40);
        n_checks++;
        if (bus.result !== 33'd0) begin
            n_fail++;
            $display("FAIL sll_big: got %h required 0", bus.result);
        end
        issue(4'b1000, 32'h8000_0000, 32'd33);
        n_checks++;
        if (bus.result !== 33'h0_FFFF_FFFF) begin
            n_fail++;
            $display("FAIL sra_big: got %h required 0ffffffff", bus.result);
        end
        issue(4'b0111, 32'h8000_0000, 32'd31);
        n_checks++;
        if (bus.result !== 33'd1) begin
            n_fail++;
            $display("FAIL srl_31: got %h required 1", bus.result);
        end
        issue(4'b0110, 32'h0000_0003, 32'd4);
        n_checks++;
        if (bus.result !== 33'h30) begin
            n_fail++;
            $display("FAIL sll_4: got %h required 30", bus.result);
        end
        issue(4'b0011, 32'hF0F0_1234, 32'h0FF0_00FF);
        n_checks++;
        if (bus.result !== 33'h0_00F0_0034) begin
            n_fail++;
            $display("FAIL and: got %h required 000f00034", bus.result);
        end
        issue(4'b0100, 32'hF000_000F, 32'h0F00_00F0);
        n_checks++;
        if (bus.result !== 33'h0_FF00_00FF) begin
            n_fail++;
            $display("FAIL or: got %h required 0ff0000ff", bus.result);
        end
    endtask

    task automatic test_mul();
        int bad;
        issue(4'b1011, 32'd50, 32'd10);
        // Operands are captured at acceptance; disturb them.
        bus.operand1 = 32'h1234_5678;
        bus.operand2 = 32'h0000_0007;
        bad = 0;
        for (int i = 1; i < 32; i++) begin
            @(posedge clock);
            #1;
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL mul_busy: got %0d cycles with valid or ready set required 0", bad);
        end
        @(posedge clock);
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.result !== 33'd500 || bus.illegal !== 1'b0) begin
            n_fail++;
            $display("FAIL mul_50_10: got v=%b r=%h i=%b required v=1 r=1f4 i=0",
                     bus.out_valid, bus.result, bus.illegal);
        end
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mul_done_ready: got %b required 1", bus.in_ready);
        end
        issue(4'b1011, 32'h0001_0000, 32'h0001_0000);
        repeat (32) @(posedge clock);
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.result !== 33'h1_0000_0000) begin
            n_fail++;
            $display("FAIL mul_high: got v=%b r=%h required v=1 r=100000000",
                     bus.out_valid, bus.result);
        end
    endtask

    task automatic test_back_to_back();
        int bad;
        @(posedge clock);
        @(negedge clock);
        bus.out_ready = 1'b0;
        bus.opcode    = 4'b0001;
        bus.operand1  = 32'd7;
        bus.operand2  = 32'd8;
        bus.in_valid  = 1'b1;
        @(posedge clock);
        #1;
        bus.opcode   = 4'b0101;
        bus.operand1 = 32'h0000_00F0;
        bus.operand2 = 32'h0000_00FF;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus.out_valid !== 1'b1 || bus.result !== 33'd15 || bus.in_ready !== 1'b0) bad++;
            @(posedge clock);
            #1;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL hold_stable: got %0d bad cycles required 0", bad);
        end
        @(negedge clock);
        bus.out_ready = 1'b1;
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL release_ready: got %b required 1", bus.in_ready);
        end
        @(posedge clock);
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.result !== 33'h0F) begin
            n_fail++;
            $display("FAIL xor_after_release: got v=%b r=%h required v=1 r=f",
                     bus.out_valid, bus.result);
        end
        for (int i = 0; i < 4; i++) begin
            bus.opcode   = 4'b0001;
            bus.operand1 = 32'(i);
            bus.operand2 = 32'd100;
            @(posedge clock);
            #1;
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b1 ||
                bus.result !== 33'(i + 100)) begin
                n_fail++;
                $display("FAIL stream_%0d: got v=%b rdy=%b r=%h required v=1 rdy=1 r=%h",
                         i, bus.out_valid, bus.in_ready, bus.result, 33'(i + 100));
            end
        end
        bus.in_valid = 1'b0;
        @(posedge clock);
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stream_drain: got %b required 0", bus.out_valid);
        end
    endtask

    task automatic test_reset_mid_op();
        int seen;
        bus.out_ready = 1'b0;
        issue(4'b0001, 32'd1, 32'd2);
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.result !== 33'd0) begin
            n_fail++;
            $display("FAIL async_reset_out: got v=%b r=%h required v=0 r=0",
                     bus.out_valid, bus.result);
        end
        @(negedge clock);
        reset_n = 1'b1;
        bus.out_ready = 1'b1;
        issue(4'b1011, 32'd3, 32'd4);
        repeat (10) @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mul_reset_idle: got rdy=%b v=%b required rdy=1 v=0",
                     bus.in_ready, bus.out_valid);
        end
        @(negedge clock);
        reset_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clock);
            #1;
            if (bus.out_valid !== 1'b0) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL mul_discarded: got %0d valid cycles required 0", seen);
        end
        issue(4'b1111, 32'd5, 32'd6);
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.result !== 33'd0 || bus.illegal !== 1'b1) begin
            n_fail++;
            $display("FAIL illegal_1111: got v=%b r=%h i=%b required v=1 r=0 i=1",
                     bus.out_valid, bus.result, bus.illegal);
        end
        issue(4'b0101, 32'hA, 32'h3);
        n_checks++;
        if (bus.result !== 33'h9 || bus.illegal !== 1'b0) begin
            n_fail++;
            $display("FAIL xor_after_illegal: got r=%h i=%b required r=9 i=0",
                     bus.result, bus.illegal);
        end
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        reset_n       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.operand1  = '0;
        bus.operand2  = '0;
        bus.opcode    = '0;
        bus.out_ready = 1'b1;
        test_reset();
        test_add();
        test_sub_cmp();
        test_logic_shift();
        test_mul();
        test_back_to_back();
        test_reset_mid_op();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
